// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// One RAM operation is in flight at a time; reads return data two cycles after the grant.
module ram_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_we,
  input  logic [2*AW-1:0]    req_addr,
  input  logic [2*WIDTH-1:0] req_wdata,
  output logic [1:0]         rsp_valid,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               ram_cs,
  output logic               ram_we,
  output logic               ram_oe,
  output logic [AW-1:0]      ram_addr,
  output logic [WIDTH-1:0]   ram_din,
  input  logic [WIDTH-1:0]   ram_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state;
  logic             ptr;
  logic             cmd_we;
  logic             cmd_owner;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] cmd_wdata;

  logic             win;
  logic [1:0]       grant;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  // The rst_n term keeps req_ready low while reset is held, even with requests pending.
  always_comb begin
    win   = ptr;
    grant = 2'b00;
    if (state == IDLE && rst_n && req_valid != 2'b00) begin
      win        = req_valid[ptr] ? ptr : ~ptr;
      grant[win] = 1'b1;
    end
  end

  assign req_ready = grant;
  assign ram_addr  = cmd_addr;
  assign ram_din   = cmd_wdata;
  assign rsp_rdata = (rsp_valid != 2'b00) ? ram_dout : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_owner <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      rsp_valid <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          rsp_valid <= 2'b00;
          if (grant != 2'b00) begin
            cmd_we    <= req_we[win];
            cmd_owner <= win;
            cmd_addr  <= win ? req_addr[AW +: AW] : req_addr[0 +: AW];
            cmd_wdata <= win ? req_wdata[WIDTH +: WIDTH] : req_wdata[0 +: WIDTH];
            ptr       <= ~win;
            ram_cs    <= 1'b1;
            ram_we    <= req_we[win];
            ram_oe    <= ~req_we[win];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          ram_oe <= 1'b0;
          if (cmd_we) begin
            state <= IDLE;
          end else begin
            rsp_valid <= cmd_owner ? 2'b10 : 2'b01;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= 2'b00;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a vector table of one- and two-requester operations
// plus hand-written backpressure, contention and mid-operation reset sequences.
module tb_ram_arbiter;

  localparam int WIDTH = 4;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_we;
  logic [2*AW-1:0]    req_addr;
  logic [2*WIDTH-1:0] req_wdata;
  logic [1:0]         rsp_valid;
  logic [WIDTH-1:0]   rsp_rdata;
  logic               ram_cs, ram_we, ram_oe;
  logic [AW-1:0]      ram_addr;
  logic [WIDTH-1:0]   ram_din;
  logic [WIDTH-1:0]   ram_dout;

  int n_pass  = 0;
  int n_total = 0;

  ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with registered read data.
  logic [WIDTH-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      if (ram_oe) ram_dout <= mem[ram_addr];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct packed {
    logic [1:0]       valid;
    logic [1:0]       we;
    logic [AW-1:0]    a0;
    logic [WIDTH-1:0] d0;
    logic [AW-1:0]    a1;
    logic [WIDTH-1:0] d1;
    logic [1:0]       first;
    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
  } vec_t;

  // Runs one vector: serves every valid requester in the expected order and checks
  // the grant, the ISSUE-cycle RAM controls and, for reads, the response cycle.
  task automatic do_vec(input vec_t v, input string tag);
    logic [1:0] pend, exp;
    int o;
    @(posedge clk); #1;
    req_valid = v.valid;
    req_we    = v.we;
    req_addr  = {v.a1, v.a0};
    req_wdata = {v.d1, v.d0};
    pend = v.valid;
    exp  = v.first;
    for (int k = 0; k < 2; k++) begin
      if (pend != 2'b00) begin
        #1 check({tag, " grant"}, 32'(req_ready), 32'(exp));
        o = exp[1] ? 1 : 0;
        @(posedge clk); #1;
        req_valid[o] = 1'b0;
        #1;
        check({tag, " issue cs"}, 32'(ram_cs), 32'd1);
        check({tag, " issue we/oe"}, 32'({ram_we, ram_oe}), v.we[o] ? 32'b10 : 32'b01);
        check({tag, " issue addr"}, 32'(ram_addr), o ? 32'(v.a1) : 32'(v.a0));
        if (v.we[o]) check({tag, " issue din"}, 32'(ram_din), o ? 32'(v.d1) : 32'(v.d0));
        check({tag, " issue ready"}, 32'(req_ready), 32'd0);
        if (!v.we[o]) begin
          @(posedge clk); #2;
          check({tag, " rsp valid"}, 32'(rsp_valid), 32'(exp));
          check({tag, " rsp data"}, 32'(rsp_rdata), o ? 32'(v.e1) : 32'(v.e0));
          check({tag, " rsp cs"}, 32'(ram_cs), 32'd0);
        end
        @(posedge clk); #1;
        check({tag, " idle rsp"}, 32'(rsp_valid), 32'd0);
        pend = pend & ~exp;
        exp  = pend;
      end
    end
  endtask

  vec_t vecs [10];
  vec_t post_rst;

  initial begin
    // Pointer starts at 0; each grant points it at the other requester.
    vecs[0] = '{2'b01, 2'b01, 5'd5,  4'hA, 5'd0,  4'h0, 2'b01, 4'h0, 4'h0};
    vecs[1] = '{2'b01, 2'b00, 5'd5,  4'h0, 5'd0,  4'h0, 2'b01, 4'hA, 4'h0};
    vecs[2] = '{2'b10, 2'b10, 5'd0,  4'h0, 5'd31, 4'hF, 2'b10, 4'h0, 4'h0};
    vecs[3] = '{2'b10, 2'b00, 5'd0,  4'h0, 5'd31, 4'h0, 2'b10, 4'h0, 4'hF};
    vecs[4] = '{2'b11, 2'b11, 5'd3,  4'h3, 5'd7,  4'h7, 2'b01, 4'h0, 4'h0};
    vecs[5] = '{2'b11, 2'b00, 5'd3,  4'h0, 5'd7,  4'h0, 2'b01, 4'h3, 4'h7};
    vecs[6] = '{2'b01, 2'b01, 5'd0,  4'h9, 5'd0,  4'h0, 2'b01, 4'h0, 4'h0};
    vecs[7] = '{2'b11, 2'b00, 5'd0,  4'h0, 5'd31, 4'h0, 2'b10, 4'h9, 4'hF};
    vecs[8] = '{2'b11, 2'b11, 5'd12, 4'h5, 5'd12, 4'hC, 2'b10, 4'h0, 4'h0};
    vecs[9] = '{2'b10, 2'b00, 5'd0,  4'h0, 5'd12, 4'h0, 2'b10, 4'h0, 4'h5};
    post_rst = '{2'b11, 2'b00, 5'd5, 4'h0, 5'd31, 4'h0, 2'b01, 4'hA, 4'hF};

    rst_n = 1'b0;
    req_valid = 2'b11; req_we = 2'b00; req_addr = '0; req_wdata = '0;
    #12;
    check("reset ready", 32'(req_ready), 32'd0);
    check("reset rsp", 32'(rsp_valid), 32'd0);
    check("reset ram ctl", 32'({ram_cs, ram_we, ram_oe}), 32'd0);
    check("reset ram addr/din", 32'({ram_addr, ram_din}), 32'd0);
    req_valid = 2'b00;
    #2 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: requester 1 arrives while requester 0's read is in flight.
    @(posedge clk); #1;
    req_valid = 2'b01; req_we = 2'b00; req_addr = {5'd31, 5'd5}; req_wdata = '0;
    #1 check("bp grant0", 32'(req_ready), 32'b01);
    @(posedge clk); #1;
    req_valid = 2'b10;
    #1 check("bp ready issue", 32'(req_ready), 32'd0);
    @(posedge clk); #2;
    check("bp ready resp", 32'(req_ready), 32'd0);
    check("bp rsp0", 32'({rsp_valid, rsp_rdata}), {26'd0, 2'b01, 4'hA});
    @(posedge clk); #2;
    check("bp grant1", 32'(req_ready), 32'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1 check("bp issue1", 32'({ram_oe, ram_addr}), {26'd0, 1'b1, 5'd31});
    @(posedge clk); #2;
    check("bp rsp1", 32'({rsp_valid, rsp_rdata}), {26'd0, 2'b10, 4'hF});

    // Continuous contention: 8 writes each, grants must alternate.
    begin
      int cnt0, cnt1, alt_err, last, total;
      bit drop0, drop1;
      cnt0 = 0; cnt1 = 0; alt_err = 0; last = -1; total = 0; drop0 = 0; drop1 = 0;
      @(posedge clk); #1;
      req_valid = 2'b11; req_we = 2'b11; req_addr = {5'd21, 5'd20}; req_wdata = {4'h2, 4'h1};
      for (int c = 0; c < 80 && total < 16; c++) begin
        if (c > 0) begin
          @(posedge clk); #1;
        end
        if (drop0) req_valid[0] = 1'b0;
        if (drop1) req_valid[1] = 1'b0;
        #1;
        if (req_ready != 2'b00) begin
          int side;
          side = req_ready[1] ? 1 : 0;
          if (side == last || req_ready == 2'b11) alt_err++;
          last = side;
          total++;
          if (side == 0) begin cnt0++; if (cnt0 == 8) drop0 = 1; end
          else begin cnt1++; if (cnt1 == 8) drop1 = 1; end
        end
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      check("cont grants0", 32'(cnt0), 32'd8);
      check("cont grants1", 32'(cnt1), 32'd8);
      check("cont alternation errors", 32'(alt_err), 32'd0);
      @(posedge clk); #1;
    end

    // Reset during the ISSUE cycle of a read.
    @(posedge clk); #1;
    req_valid = 2'b01; req_we = 2'b00; req_addr = {5'd0, 5'd7};
    @(posedge clk); #1;
    check("rstmid issue cs", 32'(ram_cs), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid ram ctl", 32'({ram_cs, ram_we, ram_oe}), 32'd0);
    check("rstmid ready/rsp", 32'({req_ready, rsp_valid}), 32'd0);
    check("rstmid addr", 32'(ram_addr), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    req_valid = 2'b00;
    #2 rst_n = 1'b1;
    begin
      int spurious;
      spurious = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #2;
        if (rsp_valid != 2'b00) spurious++;
      end
      check("rstmid no rsp", 32'(spurious), 32'd0);
    end

    // Simultaneous reads with the pointer freshly reset; RAM contents survived reset.
    do_vec(post_rst, "postrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits.
REQ-002 Parameter DEPTH, default 32, number of RAM words; AW = $clog2(DEPTH).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  2  per-requester request strobe, bit i = requester i.
REQ-006 req_ready  output  2  per-requester accept; request i transfers when req_valid[i] && req_ready[i].
REQ-007 req_we  input  2  per-requester op select, 1 = write, 0 = read.
REQ-008 req_addr  input  2*AW  per-requester address, slice [i*AW +: AW].
REQ-009 req_wdata  input  2*WIDTH  per-requester write data, slice [i*WIDTH +: WIDTH].
REQ-010 rsp_valid  output  2  one-cycle read-response strobe to owning requester.
REQ-011 rsp_rdata  output  WIDTH  read data shared by both requesters, valid when any rsp_valid bit is high.
REQ-012 ram_cs, ram_we, ram_oe  output  1 each  single-port RAM chip select, write enable, output enable.
REQ-013 ram_addr  output  AW; ram_din  output  WIDTH  RAM address and write data.
REQ-014 ram_dout  input  WIDTH  RAM read data, registered by the RAM one clock after a read is issued.

Function
REQ-015 FSM states: IDLE, ISSUE, RESP; one RAM operation in flight at a time; no operation is ever dropped.
REQ-016 IDLE: if any req_valid bit is high, grant exactly one requester; req_ready is one-hot on the granted bit and combinational from req_valid and the priority pointer.
REQ-017 In states ISSUE and RESP, req_ready = 2'b00.
REQ-018 Arbitration is round-robin with a 1-bit pointer naming the preferred requester. On contention the preferred requester wins. Otherwise the sole requester wins.
REQ-019 The pointer updates only on a grant, to the non-granted requester.
REQ-020 On grant: we, addr and wdata of the winner, plus its owner id, are registered into a command register; next state is ISSUE.
REQ-021 ISSUE, exactly one cycle: ram_cs=1, ram_addr=cmd_addr, ram_din=cmd_wdata.
REQ-022 ISSUE write: ram_we=1, ram_oe=0; next state IDLE; no rsp_valid is generated.
REQ-023 ISSUE read: ram_we=0, ram_oe=1; next state RESP.
REQ-024 RESP, exactly one cycle: rsp_valid[owner]=1, rsp_rdata=ram_dout, ram_cs=0; next state IDLE.
REQ-025 Outside ISSUE, ram_cs=ram_we=ram_oe=0. ram_addr and ram_din hold the command register value.
REQ-026 Outside RESP, rsp_valid=2'b00. rsp_rdata is don't-care but has no X on any asserted rsp_valid.
REQ-027 Latency: grant cycle T -> RAM access in cycle T+1 -> read data on rsp_rdata in cycle T+2.
REQ-028 Throughput: a write takes 2 cycles per op; a read takes 3 cycles per op.
REQ-029 Requests arriving in ISSUE or RESP are held off by req_ready=0. The requester keeps req_valid and its fields stable until accepted.
REQ-030 Both requesters continuously valid: grants strictly alternate, so neither is starved beyond one operation.
REQ-031 A requester's read following its own write to the same address returns the newly written data.

Reset
REQ-032 While rst_n=0: state=IDLE, pointer=0 (requester 0 preferred), command register=0, req_ready=0, rsp_valid=0, ram_cs=ram_we=ram_oe=0, ram_addr=0, ram_din=0.
REQ-033 Reset asserted mid-operation (ISSUE or RESP) aborts it immediately. No rsp_valid is produced for the aborted op. RAM contents are not cleared.
REQ-034 First rising edge after rst_n deasserts may grant a request.

Verification
REQ-035 Single write then read, requester 0: write addr 5 data 0xA, then read addr 5 -> ram_we pulse 1 cycle after grant, rsp_valid=2'b01 and rsp_rdata=0xA exactly 2 cycles after the read grant.
REQ-036 Simultaneous reads after reset: req_valid=2'b11, both reads -> requester 0 granted first, requester 1 next. rsp_valid sequence 2'b01 then 2'b10, 3 cycles apart.
REQ-037 Continuous contention, 8 writes each: req_valid held 2'b11 -> grants alternate 0,1,0,1,...; each requester gets exactly 8 grants; never two consecutive grants to one side.
REQ-038 Backpressure: requester 1 asserts during requester 0's read ISSUE -> req_ready[1]=0 in ISSUE and RESP, then granted in the following IDLE with fields unchanged.
REQ-039 Reset mid-read: rst_n pulled low during ISSUE of a read -> all outputs 0 asynchronously, no rsp_valid after release; a later read of a previously written addr returns the stored value.
REQ-040 Boundary address: write addr DEPTH-1 (31) data 0xF, read back -> rsp_rdata=0xF; ram_addr never exceeds 31.
